mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 180 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with HI/LO. Latency is 33 edges; MULT/MULTU take 1 edge with MDU_FAST_MULT_EN.
// No backpressure: busy stalls issue, and start/hiWrite/loWrite are ignored while busy.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic [WIDTH-1:0] writeData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state, stateNext;

    logic [5:0]         iterCnt;
    logic               opDiv;
    logic               negQuo;
    logic               negRem;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   rawA;
    logic [WIDTH-1:0]   accHi;
    logic [WIDTH-1:0]   accLo;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;
    logic               doneReg;

    logic               opSigned;
    logic               fastMul;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divDiff;
    logic               divOk;
    logic               divZero;
    logic [2*WIDTH-1:0] prodAbs;
    logic [2*WIDTH-1:0] prodRes;
    logic [WIDTH-1:0]   quoRes;
    logic [WIDTH-1:0]   remRes;

    assign opSigned = ~op[0];
    assign absA     = (opSigned && srcA[WIDTH-1]) ? -srcA : srcA;
    assign absB     = (opSigned && srcB[WIDTH-1]) ? -srcB : srcB;

`ifdef MDU_FAST_MULT_EN
    logic [2*WIDTH-1:0] fastProd;
    assign fastMul  = ~op[1];
    assign fastProd = {{WIDTH{1'b0}}, absA} * {{WIDTH{1'b0}}, absB};
`else
    assign fastMul  = 1'b0;
`endif

    // Multiply: accLo holds the multiplier, shifted out LSB-first as product bits shift in.
    assign mulSum   = accLo[0] ? ({1'b0, accHi} + {1'b0, operand}) : {1'b0, accHi};

    // Divide: partial remainder stays below the divisor, so the diff MSB is a clean borrow.
    assign divShift = {accHi, accLo[WIDTH-1]};
    assign divDiff  = divShift - {1'b0, operand};
    assign divOk    = ~divDiff[WIDTH];
    assign divZero  = (operand == '0);

    assign prodAbs  = {accHi, accLo};
    assign prodRes  = negQuo ? -prodAbs : prodAbs;
    assign quoRes   = negQuo ? -accLo : accLo;
    assign remRes   = negRem ? -accHi : accHi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = fastMul ? FINISH : RUN;
                end
            end
            RUN: begin
                if (iterCnt == 6'(WIDTH - 1)) begin
                    stateNext = FINISH;
                end
            end
            FINISH:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iterCnt <= '0;
            opDiv   <= 1'b0;
            negQuo  <= 1'b0;
            negRem  <= 1'b0;
            operand <= '0;
            rawA    <= '0;
            accHi   <= '0;
            accLo   <= '0;
            hiReg   <= '0;
            loReg   <= '0;
            doneReg <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opDiv   <= op[1];
                        negQuo  <= opSigned & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                        negRem  <= opSigned & op[1] & srcA[WIDTH-1];
                        rawA    <= srcA;
                        iterCnt <= '0;
                        accHi   <= '0;
                        if (op[1]) begin
                            accLo   <= absA;
                            operand <= absB;
                        end else begin
                            accLo   <= absB;
                            operand <= absA;
                        end
`ifdef MDU_FAST_MULT_EN
                        if (fastMul) begin
                            {accHi, accLo} <= fastProd;
                        end
`endif
                    end else begin
                        if (hiWrite) hiReg <= writeData;
                        if (loWrite) loReg <= writeData;
                    end
                end
                RUN: begin
                    iterCnt <= iterCnt + 6'd1;
                    if (opDiv) begin
                        accHi <= divOk ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
                        accLo <= {accLo[WIDTH-2:0], divOk};
                    end else begin
                        accHi <= mulSum[WIDTH:1];
                        accLo <= {mulSum[0], accLo[WIDTH-1:1]};
                    end
                end
                FINISH: begin
                    doneReg <= 1'b1;
                    if (!opDiv) begin
                        {hiReg, loReg} <= prodRes;
                    end else if (divZero) begin
                        hiReg <= rawA;
                        loReg <= '1;
                    end else begin
                        hiReg <= remRes;
                        loReg <= quoRes;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = doneReg;
    assign hi   = hiReg;
    assign lo   = loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model with latency countdown, per-cycle compare, directed literal cases.
module tb_mult_div_unit;

    localparam int W = 32;
`ifdef MDU_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] srcA = '0;
    logic [W-1:0] srcB = '0;
    logic         hiWrite = 1'b0;
    logic         loWrite = 1'b0;
    logic [W-1:0] writeData = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int compared = 0;
    int mismatched = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .srcA(srcA), .srcB(srcB), .hiWrite(hiWrite), .loWrite(loWrite),
        .writeData(writeData), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
        end
    endtask

    // Result {hi,lo} straight from MIPS arithmetic rules.
    function automatic logic [63:0] refCalc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: res = sa * sb;
            2'b01: res = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    int           mRemain = 0;
    logic         mDone = 1'b0;
    logic [W-1:0] mHi = '0, mLo = '0, pHi = '0, pLo = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mRemain = 0;
            mDone = 1'b0;
            mHi = '0;
            mLo = '0;
        end else begin
            mDone = 1'b0;
            if (mRemain == 0) begin
                if (start) begin
                    {pHi, pLo} = refCalc(op, srcA, srcB);
                    mRemain = op[1] ? DIV_LAT : MUL_LAT;
                end else begin
                    if (hiWrite) mHi = writeData;
                    if (loWrite) mLo = writeData;
                end
            end else begin
                mRemain--;
                if (mRemain == 0) begin
                    mHi = pHi;
                    mLo = pLo;
                    mDone = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc.busy", {63'd0, busy}, {63'd0, mRemain != 0});
            check("cyc.done", {63'd0, done}, {63'd0, mDone});
            check("cyc.hi", {32'd0, hi}, {32'd0, mHi});
            check("cyc.lo", {32'd0, lo}, {32'd0, mLo});
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op = o;
        srcA = a;
        srcB = b;
        @(negedge clk);
        start = 1'b0;
        srcA = $urandom;
        srcB = $urandom;
    endtask

    task automatic waitDone(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("doneSeen", {63'd0, done}, 64'd1);
    endtask

    task automatic runOp(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expHi, input logic [31:0] expLo, input int expLat);
        int lat;
        launch(o, a, b);
        waitDone(lat);
        check({name, ".lat"}, 64'(lat), 64'(expLat));
        check({name, ".hi"}, {32'd0, hi}, {32'd0, expHi});
        check({name, ".lo"}, {32'd0, lo}, {32'd0, expLo});
        @(negedge clk);
        check({name, ".donePulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        check("rst.busy", {63'd0, busy}, 64'd0);
        check("rst.done", {63'd0, done}, 64'd0);
        check("rst.hi", {32'd0, hi}, 64'd0);
        check("rst.lo", {32'd0, lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        runOp("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
        runOp("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
        runOp("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
        runOp("divu_zero", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, DIV_LAT);
        runOp("div_zero_neg", 2'b10, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, DIV_LAT);
        runOp("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT);

        // Second start mid-run must be ignored; the back-to-back start at E34 must be taken.
        launch(2'b11, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b01; srcA = 32'd2; srcB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        waitDone(lat);
        check("busyStart.lat", 64'(lat), 64'(DIV_LAT - 5));
        check("busyStart.hi", {32'd0, hi}, 64'd2);
        check("busyStart.lo", {32'd0, lo}, 64'd14);
        launch(2'b01, 32'd2, 32'd3);
        waitDone(lat);
        check("b2b.lat", 64'(lat), 64'(MUL_LAT));
        check("b2b.hi", {32'd0, hi}, 64'd0);
        check("b2b.lo", {32'd0, lo}, 64'd6);

        launch(2'b01, 32'd5, 32'd5);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midRst.busy", {63'd0, busy}, 64'd0);
        check("midRst.done", {63'd0, done}, 64'd0);
        check("midRst.hi", {32'd0, hi}, 64'd0);
        check("midRst.lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runOp("afterRst", 2'b01, 32'd5, 32'd5, 32'd0, 32'd25, MUL_LAT);

        hiWrite = 1'b1; loWrite = 1'b1; writeData = 32'h1234_5678;
        @(negedge clk);
        hiWrite = 1'b0; loWrite = 1'b0;
        check("mthi", {32'd0, hi}, 64'h1234_5678);
        check("mtlo", {32'd0, lo}, 64'h1234_5678);
        hiWrite = 1'b1; loWrite = 1'b1; writeData = 32'hDEAD_BEEF;
        start = 1'b1; op = 2'b01; srcA = 32'd1; srcB = 32'd1;
        @(negedge clk);
        start = 1'b0; hiWrite = 1'b0; loWrite = 1'b0;
        check("wrDropped.hi", {32'd0, hi}, 64'h1234_5678);
        check("wrDropped.lo", {32'd0, lo}, 64'h1234_5678);
        hiWrite = 1'b1; writeData = 32'hCAFE_F00D;
        @(negedge clk);
        hiWrite = 1'b0;
        waitDone(lat);
        check("wrBusy.hi", {32'd0, hi}, 64'd0);
        check("wrBusy.lo", {32'd0, lo}, 64'd1);
        @(negedge clk);

        runOp("multu_6x7", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, MUL_LAT);

        for (int i = 0; i < 5000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            op = 2'($urandom_range(0, 3));
            srcA = pick();
            srcB = pick();
            hiWrite = ($urandom_range(0, 5) == 0);
            loWrite = ($urandom_range(0, 5) == 0);
            writeData = $urandom;
            @(negedge clk);
        end
        start = 1'b0; hiWrite = 1'b0; loWrite = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        mismatched++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog");
    end

endmodule
